// File: rtl/reg_dump_reader_if.sv
// Bus bundle for reg_dump_reader: dump control, core stall handshake,
// register-file read port and the word stream to the sink.
interface reg_dump_reader_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        stall_req;
  logic        stall_ack;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        rf_we_mon;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        dump_last;

  modport master (
    input  start,
    input  stall_ack,
    input  rf_rd_data,
    input  rf_we_mon,
    input  dump_ready,
    output busy,
    output done,
    output stall_req,
    output rf_rd_addr,
    output dump_valid,
    output dump_addr,
    output dump_data,
    output dump_last
  );

  modport slave (
    output start,
    output stall_ack,
    output rf_rd_data,
    output rf_we_mon,
    output dump_ready,
    input  busy,
    input  done,
    input  stall_req,
    input  rf_rd_addr,
    input  dump_valid,
    input  dump_addr,
    input  dump_data,
    input  dump_last
  );
endinterface

// File: rtl/reg_dump_reader.sv
// Freezes the core, walks register-file indices FIRST_ADDR..LAST_ADDR through the
// rs1 read port and streams each word to a ready/valid sink. All outputs are registered.
module reg_dump_reader #(
  parameter int FIRST_ADDR = 0,
  parameter int LAST_ADDR  = 31
) (
  input  logic              clk,
  input  logic              rst,
  reg_dump_reader_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_SEND    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_ADDR);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_ADDR);

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_nxt;
  logic        w_capture;
  logic        w_stall_nxt;
  logic        w_rd_active_nxt;

  logic        r_stall_req;
  logic        r_busy;
  logic        r_done;
  logic [4:0]  r_rd_addr;
  logic        r_dump_valid;
  logic [4:0]  r_dump_addr;
  logic [31:0] r_dump_data;
  logic        r_dump_last;

  function automatic logic is_last(input logic [4:0] idx);
    return (idx == LAST_IDX);
  endfunction

  // Next-state and counter logic; a dropped stall_ack before capture restarts the read of the same index.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_REQ;
          w_cnt_nxt   = FIRST_IDX;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (bus.stall_ack) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_ISSUE: begin
        if (!bus.stall_ack) begin
          w_state_nxt = S_REQ;
        end else if (bus.rf_we_mon) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (!bus.stall_ack) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_SEND;
          w_capture   = 1'b1;
        end
      end
      S_SEND: begin
        if (!bus.dump_ready) begin
          w_state_nxt = S_SEND;
        end else if (is_last(r_cnt)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt   = r_cnt + 5'd1;
          // the held word is gone; the next read only starts once the core is frozen again
          w_state_nxt = bus.stall_ack ? S_ISSUE : S_REQ;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Decode of the upcoming state for the registered status outputs.
  always_comb begin
    w_stall_nxt     = 1'b0;
    w_rd_active_nxt = 1'b0;
    case (w_state_nxt)
      S_REQ:     w_stall_nxt = 1'b1;
      S_ISSUE: begin
        w_stall_nxt     = 1'b1;
        w_rd_active_nxt = 1'b1;
      end
      S_CAPTURE: begin
        w_stall_nxt     = 1'b1;
        w_rd_active_nxt = 1'b1;
      end
      S_SEND:    w_stall_nxt = 1'b1;
      default: begin
        w_stall_nxt     = 1'b0;
        w_rd_active_nxt = 1'b0;
      end
    endcase
  end

  // FSM state and index counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= FIRST_IDX;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Registered control outputs, aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_req  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_rd_addr    <= 5'd0;
      r_dump_valid <= 1'b0;
    end else begin
      r_stall_req  <= w_stall_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_DONE);
      r_rd_addr    <= w_rd_active_nxt ? w_cnt_nxt : 5'd0;
      r_dump_valid <= (w_state_nxt == S_SEND);
    end
  end

  // Output word: captured once per index and held untouched while the sink stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dump_addr <= 5'd0;
      r_dump_data <= 32'd0;
      r_dump_last <= 1'b0;
    end else begin
      if (w_capture) begin
        r_dump_addr <= r_cnt;
        r_dump_data <= bus.rf_rd_data;
      end else begin
        r_dump_addr <= r_dump_addr;
        r_dump_data <= r_dump_data;
      end
      r_dump_last <= (w_state_nxt == S_SEND) &&
                     is_last(w_capture ? r_cnt : r_dump_addr);
    end
  end

  assign bus.stall_req  = r_stall_req;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.rf_rd_addr = r_rd_addr;
  assign bus.dump_valid = r_dump_valid;
  assign bus.dump_addr  = r_dump_addr;
  assign bus.dump_data  = r_dump_data;
  assign bus.dump_last  = r_dump_last;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: register-file model, scoreboard of
// expected dump words and one task per scenario.
module tb_reg_dump_reader;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  int          n_cmp = 0;
  int          n_err = 0;
  int          done_a = 0;
  int          done_b = 0;
  logic [31:0] regs [32];
  word_t       q_a [$];
  word_t       q_b [$];

  reg_dump_reader_if a_if ();
  reg_dump_reader_if b_if ();

  reg_dump_reader #(.FIRST_ADDR(0), .LAST_ADDR(31)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.master)
  );

  reg_dump_reader #(.FIRST_ADDR(9), .LAST_ADDR(9)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.master)
  );

  always #5 clk = ~clk;

  // Register-file rs1 port: data one cycle after address, frozen while writing.
  always @(posedge clk) begin
    if (!a_if.rf_we_mon) a_if.rf_rd_data <= regs[a_if.rf_rd_addr];
    if (!b_if.rf_we_mon) b_if.rf_rd_data <= regs[b_if.rf_rd_addr];
  end

  // Scoreboard: every accepted word is popped and compared; done pulses are counted.
  always @(negedge clk) begin
    word_t e;
    if (rst) begin
      if (a_if.done) done_a++;
      if (b_if.done) done_b++;
      if (a_if.dump_valid && a_if.dump_ready) begin
        n_cmp++;
        if (q_a.size() == 0) begin
          n_err++;
          $display("FAIL a_unexpected_word: got addr %0d data %h, expected no word", a_if.dump_addr, a_if.dump_data);
        end else begin
          e = q_a.pop_front();
          if (a_if.dump_addr !== e.addr || a_if.dump_data !== e.data || a_if.dump_last !== e.last) begin
            n_err++;
            $display("FAIL a_word: got addr %0d data %h last %b, expected addr %0d data %h last %b",
                     a_if.dump_addr, a_if.dump_data, a_if.dump_last, e.addr, e.data, e.last);
          end
        end
      end
      if (b_if.dump_valid && b_if.dump_ready) begin
        n_cmp++;
        if (q_b.size() == 0) begin
          n_err++;
          $display("FAIL b_unexpected_word: got addr %0d data %h, expected no word", b_if.dump_addr, b_if.dump_data);
        end else begin
          e = q_b.pop_front();
          if (b_if.dump_addr !== e.addr || b_if.dump_data !== e.data || b_if.dump_last !== e.last) begin
            n_err++;
            $display("FAIL b_word: got addr %0d data %h last %b, expected addr %0d data %h last %b",
                     b_if.dump_addr, b_if.dump_data, b_if.dump_last, e.addr, e.data, e.last);
          end
        end
      end
      n_cmp++;
      if (a_if.dump_last && !a_if.dump_valid) begin
        n_err++;
        $display("FAIL a_last_without_valid: got dump_last 1 with dump_valid 0, expected dump_last 0");
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int first, input int last);
    for (int i = first; i <= last; i++) q_a.push_back('{5'(i), regs[i], (i == last)});
  endtask

  task automatic pulse_start_a();
    a_if.start = 1'b1;
    cycle();
    a_if.start = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, input int d0, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      cycle();
      if (done_a > d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] got [9];
    logic [31:0] want [9];
    string nm [9];
    rst = 1'b0;
    a_if.start = 1'b1;
    b_if.start = 1'b1;
    cycle();
    cycle();
    @(negedge clk);
    got  = '{32'(a_if.stall_req), 32'(a_if.busy), 32'(a_if.done), 32'(a_if.dump_valid), 32'(a_if.dump_last),
             32'(a_if.dump_addr), a_if.dump_data, 32'(a_if.rf_rd_addr), 32'(b_if.busy)};
    want = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    nm   = '{"rst_stall_req", "rst_busy", "rst_done", "rst_dump_valid", "rst_dump_last",
             "rst_dump_addr", "rst_dump_data", "rst_rf_rd_addr", "rst_b_busy"};
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (got[i] !== want[i]) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", nm[i], got[i], want[i]);
      end
    end
    cycle();
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    rst = 1'b1;
    cycle();
    @(negedge clk);
    n_cmp++;
    if (a_if.busy !== 1'b0 || b_if.busy !== 1'b0) begin
      n_err++;
      $display("FAIL start_in_reset: got busy a=%b b=%b expected 0 0", a_if.busy, b_if.busy);
    end
  endtask

  task automatic test_full_dump();
    bit ok;
    int d0 = done_a;
    a_if.stall_ack  = 1'b1;
    a_if.dump_ready = 1'b1;
    push_a(0, 31);
    pulse_start_a();
    @(negedge clk);
    n_cmp++;
    if (a_if.busy !== 1'b1 || a_if.stall_req !== 1'b1 || a_if.rf_rd_addr !== 5'd0) begin
      n_err++;
      $display("FAIL full_req_state: got busy %b stall_req %b rd_addr %0d expected 1 1 0",
               a_if.busy, a_if.stall_req, a_if.rf_rd_addr);
    end
    wait_done_a(300, d0, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL full_timeout: got no done pulse expected one within 300 cycles");
    end
    repeat (4) cycle();
    @(negedge clk);
    n_cmp++;
    if ((done_a - d0) !== 1 || q_a.size() !== 0 || a_if.busy !== 1'b0 || a_if.stall_req !== 1'b0) begin
      n_err++;
      $display("FAIL full_end: got done pulses %0d left words %0d busy %b stall_req %b expected 1 0 0 0",
               done_a - d0, q_a.size(), a_if.busy, a_if.stall_req);
    end
  endtask

  task automatic test_backpressure();
    int d0 = done_a;
    int hold = 0;
    a_if.stall_ack  = 1'b1;
    a_if.dump_ready = 1'b1;
    push_a(0, 31);
    pulse_start_a();
    for (int c = 0; c < 300; c++) begin
      cycle();
      if (a_if.dump_valid && a_if.dump_addr == 5'd9 && hold < 5) begin
        a_if.dump_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (a_if.dump_valid !== 1'b1 || a_if.dump_addr !== 5'd9 || a_if.dump_data !== 32'h2004) begin
          n_err++;
          $display("FAIL bp_hold: got valid %b addr %0d data %h expected 1 9 00002004",
                   a_if.dump_valid, a_if.dump_addr, a_if.dump_data);
        end
        hold++;
      end else begin
        a_if.dump_ready = 1'b1;
      end
      if (done_a > d0) break;
    end
    n_cmp++;
    if (hold !== 5 || (done_a - d0) !== 1 || q_a.size() !== 0) begin
      n_err++;
      $display("FAIL bp_end: got held %0d done %0d left %0d expected 5 1 0", hold, done_a - d0, q_a.size());
    end
  endtask

  task automatic test_stall_ack();
    bit ok;
    int d0 = done_a;
    a_if.stall_ack  = 1'b0;
    a_if.dump_ready = 1'b1;
    push_a(0, 31);
    pulse_start_a();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (a_if.stall_req !== 1'b1 || a_if.rf_rd_addr !== 5'd0 || a_if.dump_valid !== 1'b0) begin
        n_err++;
        $display("FAIL ack_wait: got stall_req %b rd_addr %0d valid %b expected 1 0 0",
                 a_if.stall_req, a_if.rf_rd_addr, a_if.dump_valid);
      end
      cycle();
    end
    a_if.stall_ack = 1'b1;
    wait_done_a(300, d0, ok);
    n_cmp++;
    if (!ok || q_a.size() !== 0) begin
      n_err++;
      $display("FAIL ack_end: got done %b left %0d expected 1 0", ok, q_a.size());
    end
  endtask

  task automatic test_we_mon();
    int d0 = done_a;
    bit seen = 1'b0;
    a_if.stall_ack  = 1'b1;
    a_if.dump_ready = 1'b1;
    push_a(0, 31);
    pulse_start_a();
    for (int c = 0; c < 300; c++) begin
      cycle();
      if (!seen && a_if.rf_rd_addr == 5'd5) begin
        seen = 1'b1;
        a_if.rf_we_mon = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          n_cmp++;
          if (a_if.rf_rd_addr !== 5'd5 || a_if.dump_valid !== 1'b0) begin
            n_err++;
            $display("FAIL we_hold: got rd_addr %0d valid %b expected 5 0", a_if.rf_rd_addr, a_if.dump_valid);
          end
          cycle();
        end
        a_if.rf_we_mon = 1'b0;
      end
      if (done_a > d0) break;
    end
    n_cmp++;
    if (!seen || (done_a - d0) !== 1 || q_a.size() !== 0) begin
      n_err++;
      $display("FAIL we_end: got seen %b done %0d left %0d expected 1 1 0", seen, done_a - d0, q_a.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit hit = 1'b0;
    int d0;
    a_if.stall_ack  = 1'b1;
    a_if.dump_ready = 1'b1;
    push_a(0, 31);
    pulse_start_a();
    for (int c = 0; c < 200; c++) begin
      cycle();
      if (a_if.dump_valid && a_if.dump_addr == 5'd12) begin
        a_if.dump_ready = 1'b0;
        rst = 1'b0;
        hit = 1'b1;
        break;
      end
    end
    cycle();
    @(negedge clk);
    n_cmp++;
    if (!hit || a_if.busy !== 1'b0 || a_if.stall_req !== 1'b0 || a_if.dump_valid !== 1'b0 || a_if.dump_addr !== 5'd0) begin
      n_err++;
      $display("FAIL mid_reset: got hit %b busy %b stall_req %b valid %b addr %0d expected 1 0 0 0 0",
               hit, a_if.busy, a_if.stall_req, a_if.dump_valid, a_if.dump_addr);
    end
    n_cmp++;
    if (q_a.size() !== 20) begin
      n_err++;
      $display("FAIL mid_discard: got %0d pending words expected 20", q_a.size());
    end
    q_a.delete();
    cycle();
    rst = 1'b1;
    a_if.dump_ready = 1'b1;
    cycle();
    d0 = done_a;
    push_a(0, 31);
    pulse_start_a();
    wait_done_a(300, d0, ok);
    n_cmp++;
    if (!ok || q_a.size() !== 0) begin
      n_err++;
      $display("FAIL mid_restart: got done %b left %0d expected 1 0", ok, q_a.size());
    end
  endtask

  task automatic test_single();
    int d0 = done_b;
    b_if.stall_ack  = 1'b1;
    b_if.dump_ready = 1'b1;
    q_b.push_back('{5'd9, 32'h2004, 1'b1});
    b_if.start = 1'b1;
    cycle();
    b_if.start = 1'b0;
    cycle();
    @(negedge clk);
    n_cmp++;
    if (b_if.busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_busy: got busy %b expected 1", b_if.busy);
    end
    b_if.start = 1'b1;
    cycle();
    b_if.start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      cycle();
      if (done_b > d0) break;
    end
    repeat (10) cycle();
    @(negedge clk);
    n_cmp++;
    if ((done_b - d0) !== 1 || q_b.size() !== 0 || b_if.busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_end: got done %0d left %0d busy %b expected 1 0 0", done_b - d0, q_b.size(), b_if.busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[5] = 32'd6;
    regs[9] = 32'h2004;
    rst = 1'b0;
    a_if.start = 1'b0;
    a_if.stall_ack = 1'b0;
    a_if.rf_we_mon = 1'b0;
    a_if.dump_ready = 1'b0;
    b_if.start = 1'b0;
    b_if.stall_ack = 1'b0;
    b_if.rf_we_mon = 1'b0;
    b_if.dump_ready = 1'b0;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_stall_ack();
    test_we_mon();
    test_reset_mid();
    test_single();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
